// File: rtl/period_meter.sv
// ----------------------------------------------------------------------------
// period_meter
//   Measures the number of enabled clock cycles between successive strobes on
//   `tick`. It is the inverse of a prescaled counter: it recovers the division
//   factor from a strobe train. Results can be averaged over 2^AVG_LOG2
//   periods and leave through a valid/ready output register. A missing tick
//   for TIMEOUT enabled cycles drops lock and raises a sticky overflow flag.
//
// Ports
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   clock_enable  in   qualifies counting and tick sampling
//   tick          in   event strobe (sampled only when clock_enable=1)
//   period        out  measured / averaged period, WIDTH bits
//   period_valid  out  period holds an unconsumed result
//   period_ready  in   consumer accepts the current result
//   locked        out  a tick has been seen since reset or the last timeout
//   overflow      out  sticky timeout flag, cleared by the next handshake
// ----------------------------------------------------------------------------
module period_meter #(
   parameter int WIDTH    = 12,
   parameter int AVG_LOG2 = 0,
   parameter int TIMEOUT  = 4095
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clock_enable,
   input  logic             tick,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             locked,
   output logic             overflow
);

   localparam int ACC_W = WIDTH + AVG_LOG2;
   // The period counter needs at least one bit even when no averaging is done.
   localparam int PC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic [WIDTH-1:0] LP_CNT_LAST = WIDTH'(TIMEOUT - 1);
   // With AVG_LOG2=0 this is 0, so every period is the last one of its group.
   localparam logic [PC_W-1:0]  LP_PC_LAST  = PC_W'((1 << AVG_LOG2) - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MEAS = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_acc;
   logic [PC_W-1:0]    r_pcnt;
   logic [WIDTH-1:0]   r_period;
   logic               r_valid;
   logic               r_locked;
   logic               r_overflow;

   logic [ACC_W-1:0]   w_n;
   logic [ACC_W-1:0]   w_sum;
   logic [WIDTH-1:0]   w_avg;
   logic               w_meas;
   logic               w_group_done;
   logic               w_result;
   logic               w_timeout;
   logic               w_handshake;

   // N = cnt + 1 always fits WIDTH because cnt never exceeds TIMEOUT-1.
   assign w_n          = ACC_W'(r_cnt) + ACC_W'(1);
   assign w_sum        = r_acc + w_n;
   // Truncating divide by 2^AVG_LOG2; the sum of 2^AVG_LOG2 periods <= TIMEOUT
   // always fits ACC_W, so the quotient fits WIDTH.
   assign w_avg        = w_sum[AVG_LOG2 +: WIDTH];

   assign w_meas       = (r_state == S_MEAS);
   assign w_group_done = (r_pcnt == LP_PC_LAST);
   assign w_result     = clock_enable & tick & w_meas & w_group_done;
   // A tick on the last legal cycle wins over the timeout.
   assign w_timeout    = clock_enable & ~tick & w_meas & (r_cnt == LP_CNT_LAST);
   assign w_handshake  = r_valid & period_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_pcnt     <= '0;
         r_period   <= '0;
         r_valid    <= 1'b0;
         r_locked   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (clock_enable) begin
            case (r_state)
               S_IDLE: begin
                  // First tick only starts the measurement; no result yet.
                  if (tick) begin
                     r_cnt    <= '0;
                     r_state  <= S_MEAS;
                     r_locked <= 1'b1;
                  end
               end
               S_MEAS: begin
                  if (tick) begin
                     r_cnt <= '0;
                     if (w_group_done) begin
                        r_acc  <= '0;
                        r_pcnt <= '0;
                     end else begin
                        r_acc  <= w_sum;
                        r_pcnt <= r_pcnt + PC_W'(1);
                     end
                  end else if (r_cnt == LP_CNT_LAST) begin
                     // Timeout: drop lock and discard any partial average.
                     r_state  <= S_IDLE;
                     r_locked <= 1'b0;
                     r_cnt    <= '0;
                     r_acc    <= '0;
                     r_pcnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + WIDTH'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end

         // Output register: a new result overwrites, an accept alone clears valid.
         if (w_result) begin
            r_period <= w_avg;
            r_valid  <= 1'b1;
         end else if (w_handshake) begin
            r_valid  <= 1'b0;
         end

         // Setting wins over a handshake in the same cycle.
         if (w_timeout) begin
            r_overflow <= 1'b1;
         end else if (w_handshake) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign period       = r_period;
   assign period_valid = r_valid;
   assign locked       = r_locked;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic        tk;
   logic        rdy;

   logic [11:0] a_period;
   logic        a_valid;
   logic        a_locked;
   logic        a_overflow;

   logic [11:0] b_period;
   logic        b_valid;
   logic        b_locked;
   logic        b_overflow;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   // Instance A: no averaging, short timeout.
   period_meter #(.WIDTH(12), .AVG_LOG2(0), .TIMEOUT(20)) dut_a (
      .clock        (clk),
      .reset_n      (rst_n),
      .clock_enable (ce),
      .tick         (tk),
      .period       (a_period),
      .period_valid (a_valid),
      .period_ready (rdy),
      .locked       (a_locked),
      .overflow     (a_overflow)
   );

   // Instance B: average of 4 periods, short timeout.
   period_meter #(.WIDTH(12), .AVG_LOG2(2), .TIMEOUT(20)) dut_b (
      .clock        (clk),
      .reset_n      (rst_n),
      .clock_enable (ce),
      .tick         (tk),
      .period       (b_period),
      .period_valid (b_valid),
      .period_ready (rdy),
      .locked       (b_locked),
      .overflow     (b_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive one cycle of stimulus and sample 1 time unit after the edge.
   task automatic step(input logic t, input logic e);
      tk = t;
      ce = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ce    = 1'b0;
      tk    = 1'b0;
      rdy   = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (a_period !== 12'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", a_period); end
      checks++;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", a_valid); end
      checks++;
      if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", a_locked); end
      checks++;
      if (a_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", a_overflow); end
      do_reset();
   endtask

   task automatic test_basic();
      int e;
      do_reset();
      rdy = 1'b1;
      step(1'b1, 1'b1);
      checks++;
      if (a_locked !== 1'b1 || a_valid !== 1'b0) begin
         errors++; $display("FAIL basic_first_tick locked=%0b valid=%0b exp locked=1 valid=0", a_locked, a_valid);
      end
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got=%0b exp=0", a_valid); end
         end
         exp_q.push_back(5);
         step(1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
            errors++; $display("FAIL basic_period valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
         end
      end
   endtask

   task automatic test_enable();
      int e;
      do_reset();
      rdy = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b0);   // tick while disabled must be ignored
            checks++;
            if (a_valid !== 1'b0) begin errors++; $display("FAIL enable_ignored_tick valid=%0b exp=0", a_valid); end
         end
         exp_q.push_back(4);
         step(1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
            errors++; $display("FAIL enable_period valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
         end
         step(1'b1, 1'b0);   // handshake still runs with enable low
         checks++;
         if (a_valid !== 1'b0 || a_period !== 12'(e)) begin
            errors++; $display("FAIL enable_handshake valid=%0b period=%0d exp valid=0 period=%0d", a_valid, a_period, e);
         end
      end
   endtask

   task automatic test_backpressure();
      int e;
      do_reset();
      rdy = 1'b0;
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1);
      exp_q.push_back(5);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
         errors++; $display("FAIL bp_first valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1);
         checks++;
         if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
            errors++; $display("FAIL bp_hold valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
         end
      end
      exp_q.push_back(7);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
         errors++; $display("FAIL bp_overwrite valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
      end
      rdy = 1'b1;
      step(1'b0, 1'b1);
      rdy = 1'b0;
      checks++;
      if (a_valid !== 1'b0 || a_period !== 12'd7) begin
         errors++; $display("FAIL bp_accept valid=%0b period=%0d exp valid=0 period=7", a_valid, a_period);
      end
   endtask

   task automatic test_timeout();
      int e;
      do_reset();
      rdy = 1'b1;
      step(1'b1, 1'b1);
      repeat (19) step(1'b0, 1'b1);
      checks++;
      if (a_locked !== 1'b1 || a_overflow !== 1'b0) begin
         errors++; $display("FAIL to_before locked=%0b ovf=%0b exp locked=1 ovf=0", a_locked, a_overflow);
      end
      step(1'b0, 1'b1);
      checks++;
      if (a_locked !== 1'b0 || a_overflow !== 1'b1) begin
         errors++; $display("FAIL to_fire locked=%0b ovf=%0b exp locked=0 ovf=1", a_locked, a_overflow);
      end
      step(1'b1, 1'b1);
      checks++;
      if (a_valid !== 1'b0 || a_locked !== 1'b1 || a_overflow !== 1'b1) begin
         errors++; $display("FAIL to_relock valid=%0b locked=%0b ovf=%0b exp 0/1/1", a_valid, a_locked, a_overflow);
      end
      repeat (7) step(1'b0, 1'b1);
      exp_q.push_back(8);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e) || a_overflow !== 1'b1) begin
         errors++; $display("FAIL to_after valid=%0b got=%0d ovf=%0b exp valid=1 period=%0d ovf=1", a_valid, a_period, a_overflow, e);
      end
      step(1'b0, 1'b1);
      checks++;
      if (a_overflow !== 1'b0 || a_valid !== 1'b0) begin
         errors++; $display("FAIL to_ovf_clear ovf=%0b valid=%0b exp 0/0", a_overflow, a_valid);
      end
   endtask

   task automatic test_exact_timeout();
      int e;
      do_reset();
      rdy = 1'b1;
      step(1'b1, 1'b1);
      repeat (19) step(1'b0, 1'b1);
      exp_q.push_back(20);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e) || a_locked !== 1'b1 || a_overflow !== 1'b0) begin
         errors++; $display("FAIL exact_to valid=%0b got=%0d locked=%0b ovf=%0b exp period=%0d", a_valid, a_period, a_locked, a_overflow, e);
      end
   endtask

   task automatic test_average();
      int e;
      int per[4] = '{10, 10, 11, 11};
      do_reset();
      rdy = 1'b1;
      step(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         repeat (per[k] - 1) step(1'b0, 1'b1);
         if (k == 3) exp_q.push_back(10);   // (10+10+11+11)>>2
         step(1'b1, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b_valid !== 1'b1 || b_period !== 12'(e)) begin
               errors++; $display("FAIL avg_result valid=%0b got=%0d exp=%0d", b_valid, b_period, e);
            end
         end else begin
            checks++;
            if (b_valid !== 1'b0) begin errors++; $display("FAIL avg_early valid=%0b exp=0 at period %0d", b_valid, k); end
         end
      end
      // Three periods then a timeout: the partial average is dropped.
      for (int k = 0; k < 3; k++) begin
         repeat (9) step(1'b0, 1'b1);
         step(1'b1, 1'b1);
         checks++;
         if (b_valid !== 1'b0) begin errors++; $display("FAIL avg_partial valid=%0b exp=0", b_valid); end
      end
      repeat (20) step(1'b0, 1'b1);
      checks++;
      if (b_valid !== 1'b0 || b_locked !== 1'b0 || b_overflow !== 1'b1) begin
         errors++; $display("FAIL avg_timeout valid=%0b locked=%0b ovf=%0b exp 0/0/1", b_valid, b_locked, b_overflow);
      end
   endtask

   task automatic test_async_reset();
      int e;
      do_reset();
      rdy = 1'b0;
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1);
      exp_q.push_back(5);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
         errors++; $display("FAIL ar_pre valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_valid !== 1'b0 || a_period !== 12'd0 || a_locked !== 1'b0 || a_overflow !== 1'b0) begin
         errors++; $display("FAIL ar_outputs valid=%0b period=%0d locked=%0b ovf=%0b exp all 0", a_valid, a_period, a_locked, a_overflow);
      end
      #1;
      rst_n = 1'b1;
      rdy = 1'b1;
      step(1'b1, 1'b1);
      checks++;
      if (a_valid !== 1'b0 || a_locked !== 1'b1) begin
         errors++; $display("FAIL ar_first_tick valid=%0b locked=%0b exp 0/1", a_valid, a_locked);
      end
      repeat (4) step(1'b0, 1'b1);
      exp_q.push_back(5);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (a_valid !== 1'b1 || a_period !== 12'(e)) begin
         errors++; $display("FAIL ar_second_tick valid=%0b got=%0d exp=%0d", a_valid, a_period, e);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      ce    = 1'b0;
      tk    = 1'b0;
      rdy   = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_enable();
      test_backpressure();
      test_timeout();
      test_exact_timeout();
      test_average();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the spacing, in enabled clock cycles, between successive strobes on `tick`. It is the inverse of our prescaled counter: that counter turns a fixed factor into a strobe rate, and this block recovers the factor from a strobe train. It sits in the harmonic-product-spectrum path, where it measures frame/sample strobe spacing. Results leave through a valid/ready handshake, with optional power-of-two averaging and timeout detection.

## Interface
Parameters:
- `WIDTH`, default 12: width of the measured period and of the internal cycle counter.
- `AVG_LOG2`, default 0: each result is the average of 2^AVG_LOG2 consecutive periods.
- `TIMEOUT`, default 4095: largest legal period. Legal range is 1 ≤ TIMEOUT ≤ 2^WIDTH−1.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `clock_enable`  in  1: qualifies counting and `tick` sampling.
- `tick`  in  1: event strobe, sampled only when `clock_enable`=1.
- `period`  out  WIDTH: measured (averaged) period.
- `period_valid`  out  1: `period` holds an unconsumed result.
- `period_ready`  in  1: consumer accepts the result.
- `locked`  out  1: at least one tick seen since reset or timeout.
- `overflow`  out  1: sticky timeout flag.

## Operation
- Reset values: `period`=0, `period_valid`=0, `locked`=0, `overflow`=0, state IDLE. All internal counters and the accumulator reset to 0.
- An enabled cycle is a rising edge with `clock_enable`=1. When `clock_enable`=0, the state machine, counters and `tick` are frozen or ignored. The output handshake still operates.
- State IDLE (`locked`=0):
  - An enabled cycle with `tick`=1 clears `cnt` to 0 and moves to MEAS.
  - No result is produced on this transition.
- State MEAS (`locked`=1):
  - Enabled cycle with `tick`=1: sample N = `cnt`+1, add N to the accumulator, increment the period count, clear `cnt` to 0.
  - Enabled cycle with `tick`=0: `cnt` increments.
  - Ticks on consecutive enabled cycles give N=1.
- Averaging:
  - The accumulator is WIDTH+AVG_LOG2 bits and cannot overflow, since N ≤ TIMEOUT.
  - When the 2^AVG_LOG2-th period is added, the result is (sum including this N) >> AVG_LOG2, truncating.
  - After a result, the accumulator and period count clear.
  - With AVG_LOG2=0, every tick in MEAS produces a result.
- Timeout:
  - Fires on an enabled cycle in MEAS with `tick`=0 and `cnt`=TIMEOUT−1.
  - Effects: go to IDLE, `cnt`, accumulator and period count cleared, partial average discarded, `overflow` set.
  - Tick wins: `tick`=1 with `cnt`=TIMEOUT−1 yields N=TIMEOUT as a legal result, and no timeout.
- Output register:
  - On a result: `period` is loaded and `period_valid` is set.
  - If `period_valid`=1 and `period_ready`=1 with no new result, `period_valid` clears and `period` holds its last value.
  - A new result while a previous one is unaccepted overwrites `period`; `period_valid` stays 1 and the newest value wins.
  - Accept and new result in the same cycle leaves `period_valid`=1 with the new value.
  - `period` is stable while `period_valid`=1 and no new result arrives.
- `overflow` clears on the first accepted handshake (`period_valid`&`period_ready`) after it was set. It does not clear on a handshake in the same cycle it is set.
- Reset mid-operation: asserting `reset_n`=0 immediately forces all outputs to their reset values, including any pending result.

## Timing
- Latency: tick sampled at edge e → `period`/`period_valid` updated at edge e (registered). They are visible in the following cycle.
- `locked` rises at the edge that samples the first tick. It falls at the timeout edge.
- `overflow` rises at the timeout edge.
- Handshake is combinational-free: `period_valid` falls at the edge where `period_ready`=1 was sampled.
- Throughput: one result per tick, or per 2^AVG_LOG2 ticks, sustained with no bubbles.

## Test plan
- Reset, `clock_enable`=1, `period_ready`=1, ticks every 5 cycles → `locked`=1 after tick 1. `period`=5 with a one-cycle `period_valid` after each later tick.
- `clock_enable` alternating 1/0, ticks on every 4th enabled cycle → `period`=4. Ticks presented while enable=0 are ignored.
- `period_ready`=0, periods 5 then 7 → `period`=7 with `period_valid` held. Raising `period_ready` for one cycle → `period_valid`=0 next cycle.
- TIMEOUT=20:
  - Lock, then 20 enabled cycles without a tick → `locked`=0, `overflow`=1.
  - Next tick gives no output. A tick 8 cycles later → `period`=8.
  - `overflow` clears after that result is accepted.
  - Separately, a period of exactly 20 → `period`=20 and no timeout.
- AVG_LOG2=2, periods 10,10,11,11 → exactly one result, `period`=10, after the fourth period. A timeout after 3 periods produces no result.
- Assert `reset_n` asynchronously mid-measurement with `period_valid`=1 → all outputs 0 before the next clock edge. After release, no result until two ticks are seen.
